// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch stage.
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {FETCH, DRAIN, DONE} fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// {pc, instr} FIFO: one push and up to two pops per cycle; exposes head and head+1.
module fetch_queue import fetch_pkg::*; #(
  parameter int QDEPTH = 4,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic [1:0]   pop_n,
  output logic [CW-1:0] count,
  output fetch_entry_t head,
  output logic [31:0]  head_nxt_instr
);
  fetch_entry_t store [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + CW'(push) - CW'(pop_n);
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_entry;
  end

  assign head           = store[rd_ptr];
  assign head_nxt_instr = store[rd_ptr + PW'(1)].instr;
endmodule

// File: rtl/fetch_dual.sv
// Dual-issue fetch: sync-read imem into a small queue, issue pairs to decode.
// FETCH_NOP_PAD_EN: pad an odd final instruction with ADDI x0,x0,0 instead of 0.
module fetch_dual import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] END_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_rd_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_1,
  output logic [31:0] instr_2,
  output logic [31:0] pc_1_o,
  output logic        en_flag_o,
  output logic        done_o
);
  localparam int CW = $clog2(QDEPTH) + 1;
`ifdef FETCH_NOP_PAD_EN
  localparam logic [31:0] PAD_INSTR = NOP_INSTR;
`else
  localparam logic [31:0] PAD_INSTR = 32'h0000_0000;
`endif

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, inflight_pc, head_nxt_instr;
  logic         inflight, ret_end, push, issue1, issue2, last_left;
  logic [CW-1:0] count;
  logic [CW:0]  occ;
  logic [1:0]   pop_n;
  fetch_entry_t head, push_entry;

  // Occupancy counts the read in flight so its return always has a slot.
  assign occ         = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_rd_o   = (state == FETCH) && !rst && !redirect_i && (occ < (CW+1)'(QDEPTH));
  assign imem_addr_o = imem_rd_o ? pc : 32'h0;

  assign ret_end    = inflight && (imem_data_i == END_WORD);
  assign push       = inflight && (state == FETCH) && !ret_end && !redirect_i;
  assign push_entry = '{pc: inflight_pc, instr: imem_data_i};

  assign issue2    = !stall_i && (count >= CW'(2));
  assign issue1    = !stall_i && (state == DRAIN) && (count == CW'(1));
  assign pop_n     = issue2 ? 2'd2 : (issue1 ? 2'd1 : 2'd0);
  assign last_left = !en_flag_o || !stall_i;
  assign done_o    = (state == DONE);

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk(clk), .rst(rst), .flush(redirect_i), .push(push), .push_entry(push_entry),
    .pop_n(pop_n), .count(count), .head(head), .head_nxt_instr(head_nxt_instr)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (ret_end) state_nxt = DRAIN;
      DRAIN:   if (count == '0 && !inflight && last_left) state_nxt = DONE;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_i) state <= FETCH;
    else                   state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect_i) begin
      pc       <= redirect_pc_i & ~32'h3;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_rd_o;
      if (imem_rd_o) pc <= pc + 32'd4;
    end
    inflight_pc <= pc;
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_i) begin
      instr_1 <= '0; instr_2 <= '0; pc_1_o <= '0; en_flag_o <= 1'b0;
    end else if (!stall_i) begin
      if (issue2) begin
        instr_1 <= head.instr; instr_2 <= head_nxt_instr; pc_1_o <= head.pc; en_flag_o <= 1'b1;
      end else if (issue1) begin
        instr_1 <= head.instr; instr_2 <= PAD_INSTR; pc_1_o <= head.pc; en_flag_o <= 1'b1;
      end else begin
        instr_1 <= '0; instr_2 <= '0; pc_1_o <= '0; en_flag_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_dual.sv
// Scoreboard bench for fetch_dual: program-level reference model, random programs and stalls.
module tb_fetch_dual;
  import fetch_pkg::*;

`ifdef FETCH_NOP_PAD_EN
  localparam logic [31:0] PAD = 32'h0000_0013;
`else
  localparam logic [31:0] PAD = 32'h0000_0000;
`endif

  logic clk = 0, rst, stall_i, redirect_i, imem_rd_o, en_flag_o, done_o;
  logic [31:0] redirect_pc_i, imem_addr_o, imem_data_i, instr_1, instr_2, pc_1_o;

  fetch_dual dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_rd_o(imem_rd_o), .imem_addr_o(imem_addr_o),
    .imem_data_i(imem_data_i), .instr_1(instr_1), .instr_2(instr_2), .pc_1_o(pc_1_o),
    .en_flag_o(en_flag_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] i1, i2, pc; } exp_t;
  exp_t expq[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] prog[$];
  int checks = 0, errors = 0;

  // Synchronous-read instruction memory; junk data when no read was issued.
  always @(posedge clk) begin
    if (imem_rd_o) imem_data_i <= mem.exists(imem_addr_o) ? mem[imem_addr_o] : 32'h0;
    else           imem_data_i <= $urandom | 32'h1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0] rd = 5'($urandom), rs1 = 5'($urandom), rs2 = 5'($urandom);
    logic [11:0] imm = 12'($urandom);
    case ($urandom_range(0, 7))
      0: return {7'b0000000, rs2, rs1, 3'b000, rd, OP_R};
      1: return {7'b0100000, rs2, rs1, 3'b000, rd, OP_R};
      2: return {imm, rs1, 3'b000, rd, OP_I};
      3: return {7'b0000000, rs2, rs1, 3'b100, rd, OP_R};
      4: return {imm, rs1, 3'b111, rd, OP_I};
      5: return {7'b0100000, rs2, rs1, 3'b101, rd, OP_R};
      6: return {imm, rs1, 3'b010, rd, OP_LOAD};
      default: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
    endcase
  endfunction

  // Reference model: the program at start is issued as consecutive pairs in order.
  task automatic set_prog(input logic [31:0] start, input logic clear);
    exp_t e;
    if (clear) mem.delete();
    foreach (prog[i]) mem[start + 32'(4 * i)] = prog[i];
    mem[start + 32'(4 * prog.size())] = 32'h0;
    expq.delete();
    for (int i = 0; i < prog.size(); i += 2) begin
      e.pc = start + 32'(4 * i);
      e.i1 = prog[i];
      e.i2 = (i + 1 < prog.size()) ? prog[i + 1] : PAD;
      expq.push_back(e);
    end
  endtask

  task automatic rand_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(gen_instr());
  endtask

  task automatic go(input logic [31:0] start, input logic [31:0] rpc, input logic clear);
    @(posedge clk); #1;
    redirect_i = 1; redirect_pc_i = rpc; stall_i = 0;
    set_prog(start, clear);
    @(posedge clk); #1;
    redirect_i = 0;
  endtask

  task automatic wait_done(input logic rnd_stall);
    int c = 0;
    while (!done_o && c < 400) begin
      @(posedge clk); #1;
      stall_i = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      c++;
    end
    stall_i = 0;
    check("done_reached", {31'b0, done_o}, 32'd1);
    @(negedge clk);
    check("done_no_read", {31'b0, imem_rd_o}, 32'd0);
    check("done_bubble", {31'b0, en_flag_o}, 32'd0);
    check("done_all_issued", expq.size(), 32'd0);
  endtask

  // Monitor: a pair shown with stall_i low is consumed at the next edge.
  logic hold_prev = 0, p_en;
  logic [31:0] p_i1, p_i2, p_pc;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !redirect_i) begin
      if (hold_prev) begin
        check("hold_instr_1", instr_1, p_i1);
        check("hold_instr_2", instr_2, p_i2);
        check("hold_pc_1", pc_1_o, p_pc);
        check("hold_en", {31'b0, en_flag_o}, {31'b0, p_en});
      end
      if (en_flag_o && !stall_i) begin
        if (expq.size() == 0) check("unexpected_issue", pc_1_o, 32'hFFFF_FFFF);
        else begin
          e = expq.pop_front();
          check("instr_1", instr_1, e.i1);
          check("instr_2", instr_2, e.i2);
          check("pc_1", pc_1_o, e.pc);
        end
      end
      if (!en_flag_o) check("bubble_zero", instr_1 | instr_2 | pc_1_o, 32'h0);
    end
    hold_prev = stall_i && !rst && !redirect_i;
    p_i1 = instr_1; p_i2 = instr_2; p_pc = pc_1_o; p_en = en_flag_o;
  end

  initial begin
    int c;
    rst = 1; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
    prog = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40110233};
    set_prog(32'h0, 1);
    @(posedge clk); @(negedge clk);
    check("rst_en", {31'b0, en_flag_o}, 32'd0);
    check("rst_instr", instr_1 | instr_2 | pc_1_o, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_rd", {31'b0, imem_rd_o}, 32'd0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("first_addr", imem_addr_o, 32'h0);
    wait_done(0);

    // Odd-length program: final single gets the pad slot.
    prog = '{32'h00500093, 32'h00A00113, 32'h002081B3};
    go(32'h40, 32'h40, 1);
    wait_done(0);

    // Stall mid-stream for 6 cycles.
    rand_prog(10);
    go(32'h100, 32'h100, 1);
    repeat (4) @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      #1 stall_i = 1;
      @(posedge clk);
    end
    @(negedge clk);
    check("stall_full_no_read", {31'b0, imem_rd_o}, 32'd0);
    stall_i = 0;
    wait_done(0);

    // Redirect to 0x23 with a read in flight.
    rand_prog(8);
    go(32'h0, 32'h0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_redirect_rd", {31'b0, imem_rd_o}, 32'd1);
    rand_prog(5);
    go(32'h20, 32'h23, 0);
    @(negedge clk);
    check("redir_en", {31'b0, en_flag_o}, 32'd0);
    check("redir_addr", imem_addr_o, 32'h20);
    check("redir_rd", {31'b0, imem_rd_o}, 32'd1);
    wait_done(0);

    // Reset while draining.
    rand_prog(5);
    go(32'h0, 32'h0, 1);
    c = 0;
    do begin @(negedge clk); c++; end while (!(imem_rd_o && imem_addr_o == 32'h14) && c < 50);
    check("saw_end_read", imem_addr_o, 32'h14);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    set_prog(32'h0, 1);
    @(posedge clk); @(negedge clk);
    check("drain_rst_en", {31'b0, en_flag_o}, 32'd0);
    check("drain_rst_out", instr_1 | instr_2 | pc_1_o, 32'd0);
    check("drain_rst_done", {31'b0, done_o}, 32'd0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("refetch_addr", imem_addr_o, 32'h0);
    check("refetch_rd", {31'b0, imem_rd_o}, 32'd1);
    wait_done(0);

    // PC wrap past 0xFFFFFFFC.
    rand_prog(4);
    go(32'hFFFF_FFF8, 32'hFFFF_FFF8, 1);
    @(negedge clk); check("wrap_a0", imem_addr_o, 32'hFFFF_FFF8);
    @(negedge clk); check("wrap_a1", imem_addr_o, 32'hFFFF_FFFC);
    @(negedge clk); check("wrap_a2", imem_addr_o, 32'h0000_0000);
    wait_done(0);

    // Random programs, random start alignment, random stalls.
    for (int t = 0; t < 10; t++) begin
      logic [31:0] s;
      s = 32'($urandom_range(0, 1023)) * 4 + 32'h2000;
      rand_prog($urandom_range(1, 9));
      go(s, s | 32'($urandom_range(0, 3)), 1);
      wait_done(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_dual.md
Name: fetch_dual

Overview:
- Dual-issue instruction fetch stage; the producer side of the decode stage.
- Reads one 32-bit word per cycle from a synchronous-read instruction memory into a small queue of {pc, instr} entries.
- Presents instructions to decode in pairs on instr_1/instr_2 with en_flag_o, for the subset ADD, SUB, ADDI, XOR, ANDI, SRA, LW, SW.
- Handles decode back-pressure, program end, and PC redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- QDEPTH, 4, queue entries; power of two, at least 2.
- END_WORD, 32'h0000_0000, fetched word that marks end of program.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous and active-high.
- stall_i  in  1  decode cannot accept; issue outputs hold.
- redirect_i  in  1  flush and restart fetch at redirect_pc_i.
- redirect_pc_i  in  32  new PC; bits [1:0] ignored (treated as 0).
- imem_rd_o  out  1  read strobe; data returns on the following cycle.
- imem_addr_o  out  32  byte address of the read (word aligned).
- imem_data_i  in  32  read data, valid the cycle after imem_rd_o.
- instr_1  out  32  older instruction of the issued pair.
- instr_2  out  32  younger instruction of the issued pair.
- pc_1_o  out  32  PC of instr_1 (PC of instr_2 is pc_1_o+4).
- en_flag_o  out  1  pair valid for decode this cycle.
- done_o  out  1  program end reached and fully issued; sticky.

Behaviour:
- Reset values: state=FETCH, pc=RESET_PC, queue empty, no read in flight, all outputs 0.
- States:
  - FETCH: issues reads.
  - DRAIN: END_WORD seen, no new reads.
  - DONE: queue empty; done_o=1.
- Read issue (FETCH only):
  - imem_rd_o=1 when count + inflight < QDEPTH.
  - imem_addr_o=pc; pc<=pc+4 (mod 2^32, wraps silently).
  - At most one read issued per cycle.
- Read return (cycle after imem_rd_o):
  - Word != END_WORD and state FETCH: push {addr, word}.
  - Word == END_WORD: discard, go to DRAIN. Any read returning later is discarded.
- Issue, evaluated each edge when stall_i=0:
  - count>=2: pop two. instr_1=head, instr_2=head+1, pc_1_o=head pc, en_flag_o=1.
  - state DRAIN and count==1: pop one into instr_1; instr_2 per Optional Feature; en_flag_o=1.
  - Otherwise: en_flag_o=0 and instr_1=instr_2=pc_1_o=0 (bubble).
  - Issue latency: a pair can issue at the earliest on the edge after its second word is pushed.
- stall_i=1: instr_1, instr_2, pc_1_o, en_flag_o hold their values. No pop; push and read issue continue while space allows.
- Push and pop in the same cycle are legal. The count update accounts for both, so a full queue with a simultaneous pop of 2 accepts the push.
- DRAIN->DONE when count==0, no read in flight and the last issue has left. done_o=1 from then until rst or redirect_i.
- redirect_i=1 (priority below rst, above all else):
  - Queue flushed, in-flight read discarded.
  - pc<=redirect_pc_i & ~3, state<=FETCH, done_o<=0.
  - Outputs cleared to 0 at the same edge; overrides stall_i.
- rst mid-operation: identical to the reset values on the next edge; an in-flight read is discarded.
- Instructions are issued in strict program order; no reordering or dependency checks.

Optional Feature:
- Macro FETCH_NOP_PAD_EN.
- Defined: on an odd final instruction, instr_2=32'h0000_0013 (ADDI x0,x0,0).
- Undefined: instr_2=32'h0000_0000 in that case; decode treats it as a bubble slot.
- Pairing is identical either way.

Decomposition:
- Shared package fetch_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - Fetch state enum {FETCH, DRAIN, DONE}.
  - Queue entry struct {pc[31:0], instr[31:0]}.
  - Opcode constants 7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011.
- One sub-module fetch_queue:
  - Parameterised FIFO of entries; 1 push and up to 2 pops per cycle.
  - Outputs count, head and head+1; pointers wrap mod QDEPTH.

Test Plan:
- Memory holds 0x00500093, 0x00A00113, 0x002081B3, 0x40110233, then 0; no stall.
  - Expect pair (0x00500093, 0x00A00113) with pc_1_o=0.
  - Then pair (0x002081B3, 0x40110233) with pc_1_o=8.
  - Then done_o=1 and imem_rd_o=0.
- Three instructions, then 0.
  - Second issue: instr_2=0x00000013 with FETCH_NOP_PAD_EN defined, 0x00000000 without; en_flag_o=1 in both cases.
- stall_i held for 6 cycles mid-stream.
  - Outputs constant throughout the stall.
  - imem_rd_o stops once count+inflight=QDEPTH.
  - No instruction lost or duplicated after release.
- redirect_i with redirect_pc_i=0x23 while a read is in flight.
  - Next edge: en_flag_o=0, queue empty.
  - Next read at imem_addr_o=0x20; the stale return is discarded.
- rst asserted one cycle during DRAIN.
  - Next edge: all outputs 0, pc=RESET_PC, refetch starts from 0.
- pc=0xFFFFFFFC fetched.
  - Next imem_addr_o=0x00000000 (wrap); pairing continues correctly.
